param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 10, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, almost_full threshold; legal range 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 4, almost_empty threshold; legal range 1..DEPTH-1.
REQ-005 Single clock: `clock` is an input, 1 bit, and all state is updated on its rising edge.
REQ-006 `reset` is an input, 1 bit, asynchronous, active-high.
REQ-007 data_in  input  DATA_W  write data.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 flush  input  1  synchronous request to discard contents and clear memory.
REQ-011 data_out  output  DATA_W  read data, registered.
REQ-012 data_valid  output  1  one-cycle strobe marking data_out as new.
REQ-013 data_count  output  ADDR_W+1  words stored, 0..DEPTH.
REQ-014 empty, full, almost_empty, almost_full  outputs  1 each  status flags.
REQ-015 busy  output  1  high while memory clear is in progress.
REQ-016 overflow, underflow  outputs  1 each  sticky error flags; present only under PARAM_FIFO_ERR_FLAGS_EN.

Function
REQ-017 The FSM SHALL have two states: CLEAR and RUN.
REQ-018 CLEAR SHALL write zero to one address per cycle, from 0 up to DEPTH-1, and SHALL move to RUN in the cycle after address DEPTH-1 is written. CLEAR therefore lasts DEPTH cycles.
REQ-019 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-020 push and pop SHALL be ignored while busy=1.
REQ-021 In RUN, push with full=0 SHALL write data_in at rear and advance rear modulo DEPTH.
REQ-022 In RUN, pop with empty=0 SHALL read the word at front, present it on data_out one cycle later with data_valid=1 for that one cycle, and advance front modulo DEPTH.
REQ-023 data_out SHALL hold its last value when no read is accepted.
REQ-024 Simultaneous push and pop with empty=1: only the push is accepted, and data_count goes 0->1.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: both are accepted and data_count is unchanged.
REQ-026 Simultaneous push and pop with full=1: both are accepted, data_count stays DEPTH, and the read returns the oldest word, not the word being written.
REQ-027 Flags SHALL be derived from the registered count, so each flag changes in the same cycle as data_count:
- empty: count==0
- full: count==DEPTH
- almost_full: count>=AF_LEVEL
- almost_empty: count<=AE_LEVEL
REQ-028 flush in RUN SHALL zero front, rear and data_count on the next edge and enter CLEAR. push and pop in that same cycle are dropped.
REQ-029 flush while already in CLEAR SHALL restart the clear from address 0.

Reset
REQ-030 Asserting reset SHALL immediately force the following values:
- FSM = CLEAR, clear address = 0
- front = rear = 0, data_count = 0
- data_out = 0, data_valid = 0
- empty = 1, almost_empty = 1, full = 0, almost_full = 0
- busy = 1
- overflow = underflow = 0
REQ-031 After reset deasserts, the FIFO SHALL perform the full DEPTH-cycle clear before accepting traffic.
REQ-032 Reset asserted mid-clear or mid-traffic SHALL discard all contents.

Configuration
REQ-033 With macro PARAM_FIFO_ERR_FLAGS_EN defined:
- overflow SHALL set on push while full=1 with no accepted pop.
- underflow SHALL set on pop while empty=1.
- Both flags SHALL be sticky until reset or flush.
- Neither flag SHALL be set by requests made while busy=1.
REQ-034 Without PARAM_FIFO_ERR_FLAGS_EN, the overflow and underflow ports and their logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-035 Package param_fifo_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default parameter constants.
REQ-036 Storage SHALL be the sub-module param_fifo_ram:
- simple dual-port, DATA_W x DEPTH
- one write port, one registered read port
- no reset on the array
REQ-037 Pointers, count, flags and FSM SHALL reside in param_fifo.

Verification (DATA_W=8, ADDR_W=4, AF_LEVEL=12, AE_LEVEL=4)
REQ-038 Reset then idle -> busy=1 for exactly 16 cycles, then busy=0, empty=1, data_count=0.
REQ-039 Push 8'hF1, 8'hFA, 8'h91, then pop 3 times -> data_out F1, FA, 91 in order, each with a one-cycle data_valid; empty=1 afterwards.
REQ-040 Push 16 words, 8'h00..8'h0F -> full=1 and almost_full asserts at count 12; a 17th push is dropped (overflow=1 when the macro is defined); then push+pop together -> count stays 16 and data_out=8'h00.
REQ-041 On empty, push 8'h5A and pop in the same cycle -> count=1 and no data_valid; the next pop returns 8'h5A.
REQ-042 Fill 10 words, assert flush -> count=0 on the next edge, busy=1 for 16 cycles, and pushes during busy leave count at 0.
REQ-043 Wrap test: run 40 push/pop pairs at a steady count of 5 -> data_out sequence is intact across the pointer wrap.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
// Optional feature macro: PARAM_FIFO_ERR_FLAGS_EN (sticky overflow/underflow flags).
package param_fifo_pkg;

  // Controller states: CLEAR zeroes the storage one word per cycle, RUN carries traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Default parameter values.
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_AF_MARGIN = 4;   // almost_full default sits this far below DEPTH
  localparam int DEF_AE_LEVEL  = 4;

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and param_fifo (slave).
// Optional feature macro: PARAM_FIFO_ERR_FLAGS_EN adds overflow/underflow.
interface param_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pop;
  logic              flush;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W:0]   data_count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              busy;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, push, pop, flush,
    input  data_out, data_valid, data_count, empty, full,
           almost_empty, almost_full, busy, overflow, underflow
  );
  modport slave (
    input  data_in, push, pop, flush,
    output data_out, data_valid, data_count, empty, full,
           almost_empty, almost_full, busy, overflow, underflow
  );
`else
  modport master (
    output data_in, push, pop, flush,
    input  data_out, data_valid, data_count, empty, full,
           almost_empty, almost_full, busy
  );
  modport slave (
    input  data_in, push, pop, flush,
    output data_out, data_valid, data_count, empty, full,
           almost_empty, almost_full, busy
  );
`endif
endinterface

// File: rtl/param_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Read-before-write: a read and write to the same address return the old word.
module param_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port.
  // NOTE: the array has no reset so it maps onto block RAM; the controller zeroes it by walking addresses instead.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignment keeps the read below seeing the pre-write word in the same cycle.
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with memory-clear sequencer.
// Optional feature macro: PARAM_FIFO_ERR_FLAGS_EN (sticky overflow/underflow flags).
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = (1 << ADDR_W) - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic         clock,
  input logic         reset,
  param_fifo_if.slave fifo
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] LP_CNT1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_PTR1 = ADDR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] r_front, r_rear;
  logic [ADDR_W:0]   r_count;
  logic              r_data_valid;
  logic              w_busy, w_run;
  logic              w_empty, w_full;
  logic              w_push_acc, w_pop_acc;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: flush always (re)starts the clear; the clear ends after the last address.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      CLEAR:   if (fifo.flush) w_state_nxt = CLEAR;
               else if (r_clr_addr == LP_LAST) w_state_nxt = RUN;
      RUN:     if (fifo.flush) w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = (r_state == CLEAR);
    w_run  = (r_state == RUN);
  end

  // Clear address: walks 0..DEPTH-1 in CLEAR, parked at 0 otherwise or on flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                     r_clr_addr <= '0;
    else if (w_run || fifo.flush)  r_clr_addr <= '0;
    else                           r_clr_addr <= r_clr_addr + LP_PTR1;
  end

  // Status flags come straight from the registered count.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);

  // Request acceptance; a pop on a full FIFO frees the slot the push needs.
  assign w_pop_acc  = w_run && !fifo.flush && fifo.pop && !w_empty;
  assign w_push_acc = w_run && !fifo.flush && fifo.push && (!w_full || fifo.pop);

  // Pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
    end else if (fifo.flush) begin
      r_front <= '0;
      r_rear  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_rear  <= r_rear + LP_PTR1;
      if (w_pop_acc)  r_front <= r_front + LP_PTR1;
      unique case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + LP_CNT1;
        2'b01:   r_count <= r_count - LP_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle strobe aligned with the registered read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_data_valid <= 1'b0;
    else       r_data_valid <= w_pop_acc;
  end

  // Write port is owned by the clear sequencer while busy, by push traffic otherwise.
  always_comb begin
    w_we    = w_push_acc;
    w_waddr = r_rear;
    w_wdata = fifo.data_in;
    if (w_busy) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = '0;
    end
  end

  param_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_pop_acc),
    .i_raddr (r_front),
    .o_rdata (w_rdata)
  );

  assign fifo.data_out     = w_rdata;
  assign fifo.data_valid   = r_data_valid;
  assign fifo.data_count   = r_count;
  assign fifo.empty        = w_empty;
  assign fifo.full         = w_full;
  assign fifo.almost_full  = (r_count >= LP_AF);
  assign fifo.almost_empty = (r_count <= LP_AE);
  assign fifo.busy         = w_busy;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  // Sticky error flags; only requests seen in RUN can set them, flush clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (fifo.flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_run && fifo.push && w_full && !w_pop_acc) r_overflow  <= 1'b1;
      if (w_run && fifo.pop && w_empty)               r_underflow <= 1'b1;
    end
  end

  assign fifo.overflow  = r_overflow;
  assign fifo.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (DATA_W=8, ADDR_W=4, AF=12, AE=4).
// Error-flag checks are compiled in when PARAM_FIFO_ERR_FLAGS_EN is defined.
module tb_param_fifo;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int AF     = 12;
  localparam int AE     = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  param_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fifo_bus ();

  param_fifo #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .fifo  (fifo_bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests, then sample 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic f, input logic [7:0] d);
    fifo_bus.push    = p;
    fifo_bus.pop     = q;
    fifo_bus.flush   = f;
    fifo_bus.data_in = d;
    @(posedge clock);
    #1;
    fifo_bus.push  = 1'b0;
    fifo_bus.pop   = 1'b0;
    fifo_bus.flush = 1'b0;
  endtask

  // Count edges until busy drops; bounded so a stuck clear is reported, not hung on.
  task automatic wait_clear(input string tag, input logic keep_push);
    int n;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(keep_push, 1'b0, 1'b0, 8'hC3);
      if (!fifo_bus.busy) begin
        n = k;
        break;
      end
    end
    check(tag, n, 16);
  endtask

  initial begin
    fifo_bus.data_in = '0;
    fifo_bus.push    = 1'b0;
    fifo_bus.pop     = 1'b0;
    fifo_bus.flush   = 1'b0;

    // Reset values, observed while reset is held.
    #2 reset = 1'b1;
    #10;
    check("rst_busy",  fifo_bus.busy, 1);
    check("rst_count", fifo_bus.data_count, 0);
    check("rst_empty", fifo_bus.empty, 1);
    check("rst_ae",    fifo_bus.almost_empty, 1);
    check("rst_full",  fifo_bus.full, 0);
    check("rst_af",    fifo_bus.almost_full, 0);
    check("rst_dout",  fifo_bus.data_out, 0);
    check("rst_dv",    fifo_bus.data_valid, 0);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    check("rst_ovf",   fifo_bus.overflow, 0);
    check("rst_unf",   fifo_bus.underflow, 0);
`endif

    // Clear after reset release lasts 16 cycles.
    @(negedge clock);
    reset = 1'b0;
    wait_clear("reset_clear_len", 1'b0);
    check("post_clear_empty", fifo_bus.empty, 1);
    check("post_clear_count", fifo_bus.data_count, 0);

    // Basic ordering.
    cyc(1, 0, 0, 8'hF1);
    cyc(1, 0, 0, 8'hFA);
    cyc(1, 0, 0, 8'h91);
    check("three_count", fifo_bus.data_count, 3);
    cyc(0, 1, 0, 8'h00);
    check("pop1_dout", fifo_bus.data_out, 8'hF1);
    check("pop1_dv",   fifo_bus.data_valid, 1);
    cyc(0, 1, 0, 8'h00);
    check("pop2_dout", fifo_bus.data_out, 8'hFA);
    cyc(0, 1, 0, 8'h00);
    check("pop3_dout", fifo_bus.data_out, 8'h91);
    check("pop3_dv",   fifo_bus.data_valid, 1);
    cyc(0, 0, 0, 8'h00);
    check("idle_dv",    fifo_bus.data_valid, 0);
    check("idle_hold",  fifo_bus.data_out, 8'h91);
    check("drain_empty", fifo_bus.empty, 1);

    // Fill to full with threshold checks.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 8'(i));
      if (i == 3)  check("ae_at4",  fifo_bus.almost_empty, 1);
      if (i == 4)  check("ae_at5",  fifo_bus.almost_empty, 0);
      if (i == 10) check("af_at11", fifo_bus.almost_full, 0);
      if (i == 11) check("af_at12", fifo_bus.almost_full, 1);
    end
    check("full_flag",  fifo_bus.full, 1);
    check("full_count", fifo_bus.data_count, 16);
    cyc(1, 0, 0, 8'hEE);
    check("ovf_push_count", fifo_bus.data_count, 16);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    check("ovf_flag", fifo_bus.overflow, 1);
`endif
    cyc(1, 1, 0, 8'h77);
    check("fullpp_count", fifo_bus.data_count, 16);
    check("fullpp_dout",  fifo_bus.data_out, 8'h00);
    check("fullpp_dv",    fifo_bus.data_valid, 1);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 1, 0, 8'h00);
      check("drain_dout", fifo_bus.data_out, 32'(i));
    end
    cyc(0, 1, 0, 8'h00);
    check("drain_last", fifo_bus.data_out, 8'h77);
    check("drain_empty2", fifo_bus.empty, 1);
    cyc(0, 1, 0, 8'h00);
    check("unf_dv",   fifo_bus.data_valid, 0);
    check("unf_hold", fifo_bus.data_out, 8'h77);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    check("unf_flag", fifo_bus.underflow, 1);
`endif

    // Push and pop together on empty.
    cyc(1, 1, 0, 8'h5A);
    check("emptypp_count", fifo_bus.data_count, 1);
    check("emptypp_dv",    fifo_bus.data_valid, 0);
    cyc(0, 1, 0, 8'h00);
    check("emptypp_dout",  fifo_bus.data_out, 8'h5A);
    check("emptypp_dv2",   fifo_bus.data_valid, 1);

    // Flush with a simultaneous push; pushes during the clear are dropped.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'h20 + i));
    check("fill10_count", fifo_bus.data_count, 10);
    cyc(1, 0, 1, 8'hAB);
    check("flush_count", fifo_bus.data_count, 0);
    check("flush_busy",  fifo_bus.busy, 1);
    check("flush_empty", fifo_bus.empty, 1);
`ifdef PARAM_FIFO_ERR_FLAGS_EN
    check("flush_ovf", fifo_bus.overflow, 0);
    check("flush_unf", fifo_bus.underflow, 0);
`endif
    wait_clear("flush_clear_len", 1'b1);
    check("flush_after_count", fifo_bus.data_count, 0);

    // Flush during the clear restarts it from address 0.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    cyc(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 8'h00);
    check("mid_clear_busy", fifo_bus.busy, 1);
    cyc(0, 0, 1, 8'h00);
    wait_clear("restart_clear_len", 1'b0);

    // Steady count of 5 across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h40 + i));
    check("wrap_fill", fifo_bus.data_count, 5);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 0, 8'(8'h45 + i));
      check("wrap_dout", fifo_bus.data_out, 32'(8'h40 + i));
    end
    check("wrap_count", fifo_bus.data_count, 5);

    // Asynchronous reset mid-traffic takes effect without a clock edge.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_count", fifo_bus.data_count, 0);
    check("async_busy",  fifo_bus.busy, 1);
    check("async_empty", fifo_bus.empty, 1);
    check("async_dout",  fifo_bus.data_out, 0);
    check("async_dv",    fifo_bus.data_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    wait_clear("reset2_clear_len", 1'b0);
    check("reset2_empty", fifo_bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
